// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the parameterised serial pattern detector.
package seq_det_pkg;

  localparam int          PATTERN_W_DEF = 8;
  localparam int          COUNT_W_DEF   = 8;
  localparam logic [7:0]  RESET_PATTERN = 8'b0001_0110;  // "10110", right-aligned
  localparam int          RESET_LEN     = 5;

  // Width needed to hold a length value in 0..pw.
  function automatic int len_w(input int pw);
    return $clog2(pw + 1);
  endfunction

  // Low n bits set; saturates to all ones for n >= 32.
  function automatic logic [31:0] len_mask(input logic [31:0] n);
    if (n >= 32'd32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all ones; clr wins over inc.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                   count <= '0;
    else if (clr)                count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
  end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with runtime-loadable pattern, length and
// overlap mode, registered match pulse and saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                   PATTERN_W     = seq_det_pkg::PATTERN_W_DEF,
  parameter int                   COUNT_W       = seq_det_pkg::COUNT_W_DEF,
  parameter logic [PATTERN_W-1:0] RESET_PATTERN = PATTERN_W'(seq_det_pkg::RESET_PATTERN),
  parameter int                   RESET_LEN     = seq_det_pkg::RESET_LEN,
  parameter bit                   RESET_OVERLAP = 1'b1,
  localparam int                  LEN_W         = len_w(PATTERN_W)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in,
  input  logic                 cfg_load,
  input  logic [PATTERN_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic                 cfg_overlap,
  input  logic                 clr_count,
  output logic                 match,
  output logic [COUNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]     hist_fill
);

  localparam logic [LEN_W-1:0] FULL = LEN_W'(PATTERN_W);

  logic [PATTERN_W-1:0] hist, pattern, nh, mask;
  logic [LEN_W-1:0]     len, fill_nxt;
  logic                 overlap, sample, hit;
  logic [31:0]          mask32;

  assign sample = in_valid && !cfg_load;

  always_comb begin
    nh       = {hist[PATTERN_W-2:0], in};
    mask32   = len_mask(32'(len));
    mask     = mask32[PATTERN_W-1:0];
    // Lengths of 0 or beyond PATTERN_W are held but can never match.
    hit      = (len != '0) && (len <= FULL) &&
               (({1'b0, hist_fill} + 1'b1) >= {1'b0, len}) &&
               (((nh ^ pattern) & mask) == '0);
    fill_nxt = hist_fill;
    if (hit && !overlap)       fill_nxt = '0;
    else if (hist_fill != FULL) fill_nxt = hist_fill + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist      <= '0;
      hist_fill <= '0;
      match     <= 1'b0;
      pattern   <= RESET_PATTERN;
      len       <= LEN_W'(RESET_LEN);
      overlap   <= RESET_OVERLAP;
    end else begin
      match <= sample && hit;
      if (cfg_load) begin
        pattern   <= cfg_pattern;
        len       <= cfg_len;
        overlap   <= cfg_overlap;
        hist      <= '0;
        hist_fill <= '0;
      end else if (in_valid) begin
        // In non-overlap mode bits still shift in, but fill restarts at 0.
        hist      <= nh;
        hist_fill <= fill_nxt;
      end
    end
  end

  sat_counter #(.WIDTH(COUNT_W)) u_count (
    .clk   (clk),
    .reset (reset),
    .inc   (sample && hit),
    .clr   (clr_count),
    .count (match_count)
  );

endmodule

// File: tb/tb_seq_detector_param.sv
// Scoreboard bench for seq_detector_param: expected match bits are queued as
// each input is driven and popped once the registered pulse is visible.
module tb_seq_detector_param;

  logic       clk = 1'b0, reset = 1'b1;
  logic       in_valid = 1'b0, in = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b0, clr_count = 1'b0;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic       match;
  logic [7:0] match_count;
  logic [3:0] hist_fill;

  int n_pass = 0, n_total = 0;
  bit exp_q[$];
  bit e;

  seq_detector_param dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in(in),
    .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_overlap(cfg_overlap), .clr_count(clr_count),
    .match(match), .match_count(match_count), .hist_fill(hist_fill)
  );

  always #5 clk = ~clk;

  // Drive one cycle; strobes are dropped afterwards. Returns 1 ns past the edge.
  task automatic step(input logic v, input logic b);
    in_valid = v; in = b;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_load = 1'b0; clr_count = 1'b0;
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #2 reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] p, input logic [3:0] l, input logic ov);
    cfg_pattern = p; cfg_len = l; cfg_overlap = ov; cfg_load = 1'b1;
    step(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; #3;
    n_total++;
    if (match !== 1'b0 || match_count !== 8'd0 || hist_fill !== 4'd0)
      $display("FAIL reset_state: got match=%b count=%0d fill=%0d, want 0/0/0", match, match_count, hist_fill);
    else n_pass++;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    bit s[5] = '{1, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(i == 4);
      step(1'b1, s[i]);
      e = exp_q.pop_front(); n_total++;
      if (match !== e) $display("FAIL basic_match bit%0d: got %b want %b", i, match, e);
      else n_pass++;
    end
    n_total++;
    if (match_count !== 8'd1 || hist_fill !== 4'd5)
      $display("FAIL basic_count: got count=%0d fill=%0d want 1/5", match_count, hist_fill);
    else n_pass++;
  endtask

  task automatic test_overlap();
    bit s[8] = '{1, 0, 1, 1, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(i == 4 || i == 7);
      step(1'b1, s[i]);
      e = exp_q.pop_front(); n_total++;
      if (match !== e) $display("FAIL overlap1 bit%0d: got %b want %b", i, match, e);
      else n_pass++;
    end
    n_total++;
    if (match_count !== 8'd2) $display("FAIL overlap1_count: got %0d want 2", match_count);
    else n_pass++;
    load(8'b1_0110, 4'd5, 1'b0);
    clr_count = 1'b1; step(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(i == 4);
      step(1'b1, s[i]);
      e = exp_q.pop_front(); n_total++;
      if (match !== e) $display("FAIL overlap0 bit%0d: got %b want %b", i, match, e);
      else n_pass++;
    end
    n_total++;
    if (match_count !== 8'd1 || hist_fill !== 4'd3)
      $display("FAIL overlap0_count: got count=%0d fill=%0d want 1/3", match_count, hist_fill);
    else n_pass++;
  endtask

  task automatic test_stall();
    bit s[5] = '{1, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(i == 4);
      step(1'b1, s[i]);
      e = exp_q.pop_front(); n_total++;
      if (match !== e) $display("FAIL stall_bit%0d: got %b want %b", i, match, e);
      else n_pass++;
      for (int k = 0; k < 3; k++) begin
        exp_q.push_back(1'b0);
        step(1'b0, ~s[i]);
        e = exp_q.pop_front(); n_total++;
        if (match !== e) $display("FAIL stall_gap%0d_%0d: got %b want %b", i, k, match, e);
        else n_pass++;
      end
    end
    n_total++;
    if (match_count !== 8'd1) $display("FAIL stall_count: got %0d want 1", match_count);
    else n_pass++;
  endtask

  task automatic test_ones();
    do_reset();
    load(8'b1111, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(i >= 3);
      step(1'b1, 1'b1);
      e = exp_q.pop_front(); n_total++;
      if (match !== e) $display("FAIL ones_bit%0d: got %b want %b", i, match, e);
      else n_pass++;
    end
    n_total++;
    if (match_count !== 8'd4) $display("FAIL ones_count: got %0d want 4", match_count);
    else n_pass++;
    // Load alongside a valid bit that would otherwise complete a match.
    cfg_pattern = 8'b1111; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_load = 1'b1;
    exp_q.push_back(1'b0);
    step(1'b1, 1'b1);
    e = exp_q.pop_front(); n_total++;
    if (match !== e || hist_fill !== 4'd0)
      $display("FAIL load_with_valid: got match=%b fill=%0d want %b/0", match, hist_fill, e);
    else n_pass++;
    // Lengths 0 and 9 must never match, even on an all-zero pattern.
    for (int l = 0; l < 2; l++) begin
      load(8'h00, (l == 0) ? 4'd0 : 4'd9, 1'b1);
      for (int i = 0; i < 10; i++) begin
        exp_q.push_back(1'b0);
        step(1'b1, 1'b0);
        e = exp_q.pop_front(); n_total++;
        if (match !== e) $display("FAIL badlen%0d_bit%0d: got %b want %b", l, i, match, e);
        else n_pass++;
      end
    end
  endtask

  task automatic test_saturate();
    int bad = 0;
    do_reset();
    load(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 300; i++) begin
      exp_q.push_back(1'b1);
      step(1'b1, 1'b1);
      e = exp_q.pop_front();
      if (match !== e) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL sat_stream: got %0d missed pulses want 0", bad);
    else n_pass++;
    n_total++;
    if (match_count !== 8'd255 || hist_fill !== 4'd8)
      $display("FAIL sat_count: got count=%0d fill=%0d want 255/8", match_count, hist_fill);
    else n_pass++;
    clr_count = 1'b1;
    exp_q.push_back(1'b1);
    step(1'b1, 1'b1);
    e = exp_q.pop_front(); n_total++;
    if (match !== e || match_count !== 8'd0)
      $display("FAIL clr_with_hit: got match=%b count=%0d want %b/0", match, match_count, e);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit s[5] = '{1, 0, 1, 1, 0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(1'b0);
      step(1'b1, s[i]);
      e = exp_q.pop_front(); n_total++;
      if (match !== e) $display("FAIL mid_bit%0d: got %b want %b", i, match, e);
      else n_pass++;
    end
    do_reset();
    exp_q.push_back(1'b0);
    step(1'b1, 1'b0);
    e = exp_q.pop_front(); n_total++;
    if (match !== e || hist_fill !== 4'd1 || match_count !== 8'd0)
      $display("FAIL mid_after: got match=%b fill=%0d count=%0d want %b/1/0", match, hist_fill, match_count, e);
    else n_pass++;
    // A pulse that is already visible must be killed by reset.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, s[i]);
    n_total++;
    if (match !== 1'b1) $display("FAIL pending_pre: got %b want 1", match);
    else n_pass++;
    #1 reset = 1'b1; #1;
    n_total++;
    if (match !== 1'b0 || match_count !== 8'd0)
      $display("FAIL pending_kill: got match=%b count=%0d want 0/0", match, match_count);
    else n_pass++;
    #1 reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_stall();
    test_ones();
    test_saturate();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
